key_scan_ctrl: RTL and testbench
================================

Name: key_scan_ctrl

Overview:
- Debounce controller and scheduler for a bank of NUM_KEYS push-buttons.
- Generates the sample tick internally and round-robins one shared 3-sample debounce engine across all keys.
- Turns debounced level changes into press/release events, which are delivered one at a time over a valid/ready handshake.
- Sits between raw board pins (already synchronised upstream) and the user-input logic.

Parameters:
NUM_KEYS, 4, number of buttons; 1..16.
TICK_DIV, 50000, sys_clk cycles per scan tick; ≥ NUM_KEYS+1.
LONG_TICKS, 100, per-key scan visits a key must stay held before a long-press event (only with the optional feature).

Ports:
sys_clk  in  1  system clock.
sys_rst_n  in  1  asynchronous, active-low reset.
i_btn  in  NUM_KEYS  raw key levels, 1 = pressed.
o_level  out  NUM_KEYS  debounced key levels.
o_evt_valid  out  1  event pending.
o_evt_key  out  4  key index of the pending event.
o_evt_type  out  2  event type: 0 = press, 1 = release, 2 = long press.
i_evt_ready  in  1  consumer accepts the event.
o_overflow  out  1  sticky flag: an event was dropped.
i_clr_ovf  in  1  one-cycle pulse; clears o_overflow.

Behaviour:
- Async reset values: all outputs 0; tick counter 0; scan pointer 0; all key histories 3'b000; all hold counters 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - clk_flag is high for exactly 1 cycle when the count equals TICK_DIV-1.
- Scan:
  - On each clk_flag, key k = scan pointer is serviced: hist[k] <= {hist[k][1:0], i_btn[k]}.
  - The pointer then advances k -> k+1, wrapping NUM_KEYS-1 -> 0.
  - Each key is therefore sampled once every NUM_KEYS ticks.
- Debounce rule:
  - o_level[k] = &hist[k], registered; updates 1 cycle after the servicing tick.
  - Rising needs 3 consecutive high samples of that key; any single low sample drops the level.
- Events, detected in the cycle o_level[k] updates:
  - 0 -> 1 gives a press event.
  - 1 -> 0 gives a release event.
  - At most one event is generated per tick, because only one key is serviced per tick.
- Event register (1 entry):
  - Loaded when it is empty, or in the same cycle as it drains (o_evt_valid & i_evt_ready).
  - o_evt_valid, o_evt_key and o_evt_type are held stable while valid & !ready.
  - A new event arriving while the register is occupied and not draining is dropped, and o_overflow <= 1.
- Overflow clear:
  - i_clr_ovf clears o_overflow.
  - If a drop occurs in the same cycle as i_clr_ovf, set wins.
- Boundaries:
  - NUM_KEYS=1: the pointer stays at 0.
  - A key held through reset: o_level rises at that key's 3rd post-reset visit and then emits a press.
  - i_btn changes between visits are invisible; glitches shorter than NUM_KEYS*TICK_DIV cycles may be missed entirely, by design.
- Latency: from the 3rd high sample's clk_flag, o_level rises 1 cycle later and o_evt_valid rises 2 cycles later (register empty).

Optional Feature:
- Macro KEY_SCAN_CTRL_LONG_EN.
- Defined:
  - Each key has a 7-bit-or-wider hold counter.
  - The counter increments on that key's service tick while o_level[k]=1, and saturates at LONG_TICKS.
  - Exactly when it reaches LONG_TICKS, a long-press event (type 2) is emitted once per hold.
  - The counter is cleared when o_level[k] falls.
  - Long-press and press/release share the same event register and overflow rules.
- Not defined: no hold counters; type 2 is never produced; o_evt_type[1] is tied to 0.

Test Plan:
- Setup for all scenarios: NUM_KEYS=4, TICK_DIV=8, reset released at t0.
  - All key-level outputs = 0.
  - The first clk_flag comes 8 cycles after reset release.
  - Key 0 is serviced on ticks 1, 5, 9, …
- Hold i_btn=4'b0100 with i_evt_ready=1:
  - o_level[2] rises 1 cycle after tick 11 (key 2's 3rd visit).
  - Next cycle: o_evt_valid=1 for 1 cycle, key=2, type=0.
- Press key 1, keep i_evt_ready=0, then press key 3:
  - Key 1's press is held in the register.
  - Key 3's press is dropped and o_overflow=1.
  - Raise ready: the key-1 event drains.
  - Pulse i_clr_ovf: o_overflow=0.
- Key 0 high on visits 1 and 2, low on visit 3, high afterwards:
  - No event until three consecutive high samples.
  - o_level[0] rises after visit 6 (the visit on tick 21).
- Assert sys_rst_n=0 mid-hold while o_evt_valid=1:
  - All outputs clear asynchronously.
  - After release, the key re-debounces from 3'b000.
- With KEY_SCAN_CTRL_LONG_EN and LONG_TICKS=5, hold key 1:
  - Press event, then exactly one type-2 event after key 1's 5th held visit.
  - On release: a release event, and no further type-2 events.

Source files
------------

// File: rtl/key_scan_ctrl_if.sv
// Event delivery handshake between key_scan_ctrl (master) and its consumer (slave).
interface key_scan_ctrl_if;
    logic       o_evt_valid;
    logic [3:0] o_evt_key;
    logic [1:0] o_evt_type;
    logic       i_evt_ready;

    modport master (output o_evt_valid, o_evt_key, o_evt_type, input  i_evt_ready);
    modport slave  (input  o_evt_valid, o_evt_key, o_evt_type, output i_evt_ready);
endinterface

// File: rtl/key_scan_ctrl.sv
// Round-robin 3-sample debouncer for NUM_KEYS buttons with a 1-entry press/release event register.
// Optional long-press events are enabled by defining KEY_SCAN_CTRL_LONG_EN.
module key_scan_ctrl #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned LONG_TICKS = 100
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] i_btn,
    output logic [NUM_KEYS-1:0] o_level,
    key_scan_ctrl_if.master     evt,
    output logic                o_overflow,
    input  logic                i_clr_ovf
);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PTR_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [TICK_W-1:0]   tick_q;
    logic                clk_flag;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    svc_key_q;
    logic                svc_q;
    logic [2:0]          hist_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_d;
    logic [NUM_KEYS-1:0] level_q;
    logic                long_hit_q;
    logic                st_valid_d, st_valid_q;
    logic [3:0]          st_key_q;
    logic [1:0]          st_type_d, st_type_q;
    logic                evt_valid_d, evt_valid_q;
    logic [3:0]          evt_key_d, evt_key_q;
    logic [1:0]          evt_type_d, evt_type_q;
    logic                ovf_d, ovf_q;

    assign clk_flag = (tick_q == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tick_q <= '0;
        else            tick_q <= clk_flag ? '0 : tick_q + TICK_W'(1);
    end

    // Service one key per tick; svc_q/svc_key_q mark the cycle its level may change.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_q     <= '0;
            svc_q     <= 1'b0;
            svc_key_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) hist_q[k] <= 3'b000;
        end else begin
            svc_q <= clk_flag;
            if (clk_flag) begin
                hist_q[ptr_q] <= {hist_q[ptr_q][1:0], i_btn[ptr_q]};
                svc_key_q     <= ptr_q;
                ptr_q         <= (ptr_q == PTR_W'(NUM_KEYS - 1)) ? '0 : ptr_q + PTR_W'(1);
            end
        end
    end

    always_comb begin
        level_d = '0;
        for (int k = 0; k < NUM_KEYS; k++) level_d[k] = &hist_q[k];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) level_q <= '0;
        else            level_q <= level_d;
    end

`ifdef KEY_SCAN_CTRL_LONG_EN
    localparam int unsigned CNT_RAW_W = $clog2(LONG_TICKS + 1);
    localparam int unsigned CNT_W     = (CNT_RAW_W < 7) ? 7 : CNT_RAW_W;

    logic [CNT_W-1:0] hold_q [NUM_KEYS];

    // Hold counter saturates at LONG_TICKS so the long-press fires once per hold.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            long_hit_q <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) hold_q[k] <= '0;
        end else begin
            long_hit_q <= 1'b0;
            if (clk_flag && level_q[ptr_q] && (hold_q[ptr_q] != CNT_W'(LONG_TICKS))) begin
                hold_q[ptr_q] <= hold_q[ptr_q] + CNT_W'(1);
                long_hit_q    <= (hold_q[ptr_q] == CNT_W'(LONG_TICKS - 1));
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (level_q[k] && !level_d[k]) hold_q[k] <= '0;
            end
        end
    end
`else
    assign long_hit_q = 1'b0;
`endif

    // A level change on the serviced key outranks a long-press from the same visit.
    always_comb begin
        st_valid_d = 1'b0;
        st_type_d  = 2'd0;
        if (svc_q) begin
            if (level_d[svc_key_q] != level_q[svc_key_q]) begin
                st_valid_d = 1'b1;
                st_type_d  = level_d[svc_key_q] ? 2'd0 : 2'd1;
            end else if (long_hit_q) begin
                st_valid_d = 1'b1;
                st_type_d  = 2'd2;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_valid_q <= 1'b0;
            st_key_q   <= '0;
            st_type_q  <= '0;
        end else begin
            st_valid_q <= st_valid_d;
            st_key_q   <= 4'(svc_key_q);
            st_type_q  <= st_type_d;
        end
    end

    // Single-entry event register; a new event that cannot be accepted sets the sticky overflow.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        evt_type_d  = evt_type_q;
        ovf_d       = ovf_q;
        if (evt_valid_q && evt.i_evt_ready) evt_valid_d = 1'b0;
        if (i_clr_ovf) ovf_d = 1'b0;
        if (st_valid_q) begin
            if (!evt_valid_q || evt.i_evt_ready) begin
                evt_valid_d = 1'b1;
                evt_key_d   = st_key_q;
                evt_type_d  = st_type_q;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_type_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_type_q  <= evt_type_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_level         = level_q;
    assign o_overflow      = ovf_q;
    assign evt.o_evt_valid = evt_valid_q;
    assign evt.o_evt_key   = evt_key_q;
    assign evt.o_evt_type  = evt_type_q;
endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: directed scenarios plus randomized stimulus against a behavioural model.
module tb_key_scan_ctrl;
    localparam int NK = 4;
    localparam int TD = 8;
    localparam int LT = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] btn   = '0;
    logic          clr   = 1'b0;
    logic [NK-1:0] level;
    logic          ovf;
    int            n_chk  = 0;
    int            n_fail = 0;

    key_scan_ctrl_if evt_if ();

    key_scan_ctrl #(.NUM_KEYS(NK), .TICK_DIV(TD), .LONG_TICKS(LT)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .i_btn     (btn),
        .o_level   (level),
        .evt       (evt_if.master),
        .o_overflow(ovf),
        .i_clr_ovf (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-key run length of consecutive high samples, visits from the edge count.
    int            m_edge;
    int            run [NK];
    int            hc  [NK];
    logic [NK-1:0] m_lvl;
    bit            lp_v, lp_lvl, lp_long;
    int            lp_k;
    bit            st_v;
    int            st_k, st_t;
    bit            m_v, m_ovf;
    int            m_k, m_t;

    always @(posedge clk or negedge rst_n) begin : model
        bit n_v, drop;
        int n_k, n_t, k;
        if (!rst_n) begin
            m_edge = 0; m_lvl = '0; lp_v = 0; lp_lvl = 0; lp_long = 0; lp_k = 0;
            st_v = 0; st_k = 0; st_t = 0; m_v = 0; m_ovf = 0; m_k = 0; m_t = 0;
            for (int i = 0; i < NK; i++) begin run[i] = 0; hc[i] = 0; end
        end else begin
            drop = 0;
            if (st_v) begin
                if (!m_v || evt_if.i_evt_ready) begin m_v = 1; m_k = st_k; m_t = st_t; end
                else drop = 1;
            end else if (m_v && evt_if.i_evt_ready) m_v = 0;
            if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
            n_v = 0; n_k = 0; n_t = 0;
            if (lp_v) begin
                if (m_lvl[lp_k] != lp_lvl) begin
                    n_v = 1; n_k = lp_k; n_t = lp_lvl ? 0 : 1;
                    if (!lp_lvl) hc[lp_k] = 0;
                end else if (lp_long) begin
                    n_v = 1; n_k = lp_k; n_t = 2;
                end
                m_lvl[lp_k] = lp_lvl;
            end
            st_v = n_v; st_k = n_k; st_t = n_t;
            m_edge++;
            lp_v = 0; lp_long = 0;
            if (m_edge % TD == 0) begin
                k = (m_edge / TD - 1) % NK;
                run[k] = btn[k] ? run[k] + 1 : 0;
                lp_v = 1; lp_k = k; lp_lvl = (run[k] >= 3);
`ifdef KEY_SCAN_CTRL_LONG_EN
                if (m_lvl[k] && hc[k] < LT) begin
                    hc[k]++;
                    lp_long = (hc[k] == LT);
                end
`endif
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("level", 32'(level), 32'(m_lvl));
            check("evt_valid", 32'(evt_if.o_evt_valid), 32'(m_v));
            check("overflow", 32'(ovf), 32'(m_ovf));
            if (m_v) begin
                check("evt_key", 32'(evt_if.o_evt_key), 32'(m_k));
                check("evt_type", 32'(evt_if.o_evt_type), 32'(m_t));
            end
        end
    end

    task automatic to_edge(input int n);
        while (m_edge < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic expect_evt(input string name, input int k, input int t);
        check({name, "_valid"}, 32'(evt_if.o_evt_valid), 32'd1);
        check({name, "_key"}, 32'(evt_if.o_evt_key), 32'(k));
        check({name, "_type"}, 32'(evt_if.o_evt_type), 32'(t));
    endtask

    initial begin
        evt_if.i_evt_ready = 1'b1;

        // Single key press with consumer always ready.
        btn = 4'b0100;
        do_reset();
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(evt_if.o_evt_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        to_edge(88);  check("k2_level_before", 32'(level), 32'd0);
        to_edge(89);  check("k2_level_rise", 32'(level), 32'h4);
                      check("k2_valid_early", 32'(evt_if.o_evt_valid), 32'd0);
        to_edge(90);  expect_evt("k2_press", 2, 0);
        to_edge(91);  check("k2_drained", 32'(evt_if.o_evt_valid), 32'd0);

        // Blocked register: key 1 held, key 3 dropped.
        evt_if.i_evt_ready = 1'b0;
        btn = 4'b1010;
        do_reset();
        to_edge(97);  check("ovf_before_drop", 32'(ovf), 32'd0);
        to_edge(99);  expect_evt("k1_held", 1, 0);
                      check("ovf_set", 32'(ovf), 32'd1);
        evt_if.i_evt_ready = 1'b1;
        to_edge(100); check("k1_drain", 32'(evt_if.o_evt_valid), 32'd0);
                      check("ovf_sticky", 32'(ovf), 32'd1);
        clr = 1'b1;
        to_edge(101); check("ovf_cleared", 32'(ovf), 32'd0);
        clr = 1'b0;

        // Bounce on key 0: low third sample restarts the count.
        btn = 4'b0001;
        do_reset();
        to_edge(50);  btn = 4'b0000;
        to_edge(80);  btn = 4'b0001;
        to_edge(168); check("k0_bounce_low", 32'(level), 32'd0);
        to_edge(169); check("k0_bounce_rise", 32'(level), 32'd1);
        to_edge(170); expect_evt("k0_press", 0, 0);

        // Asynchronous reset while an event is pending.
        evt_if.i_evt_ready = 1'b0;
        btn = 4'b0001;
        do_reset();
        to_edge(120); expect_evt("k0_pending", 0, 0);
        rst_n = 1'b0;
        #1;
        check("async_level", 32'(level), 32'd0);
        check("async_valid", 32'(evt_if.o_evt_valid), 32'd0);
        check("async_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        to_edge(72);  check("rehist_low", 32'(level), 32'd0);
        to_edge(73);  check("rehist_rise", 32'(level), 32'd1);
        evt_if.i_evt_ready = 1'b1;

`ifdef KEY_SCAN_CTRL_LONG_EN
        // Long press on key 1, then release.
        btn = 4'b0010;
        do_reset();
        to_edge(82);  expect_evt("long_press", 1, 0);
        to_edge(241); check("long_early", 32'(evt_if.o_evt_valid), 32'd0);
        to_edge(242); expect_evt("long_evt", 1, 2);
        to_edge(250); btn = 4'b0000;
        to_edge(274); expect_evt("long_release", 1, 1);
        to_edge(420);
`endif

        // Randomized stimulus checked only by the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) btn[$urandom_range(0, NK - 1)] ^= 1'b1;
            evt_if.i_evt_ready = (c % 1000 < 500) ? ($urandom_range(0, 3) != 0)
                                                   : ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 49) == 0);
        end
        clr = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
